xleds_ctrl: RTL and testbench

//  Parametrised multi-mode LED driver for the board LED bank.

---
 rtl/xleds_pkg.sv | 18 +
 rtl/xleds_tick.sv | 33 +++
 rtl/xleds_ctrl.sv | 157 +++++++++++++++
 tb/tb_xleds_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xleds_pkg.sv
// Shared definitions for the LED driver: channel mode encoding and width.
//   mode_t       2-bit channel mode
//   MODE_STATIC  led = val
//   MODE_BLINK   led = global blink phase ^ val
//   MODE_PWM     led = (global pwm counter < duty)
//   MODE_PULSE   led = 1 while the one-shot counter runs
package xleds_pkg;

   localparam int MODE_W = 2;

   typedef logic [MODE_W-1:0] mode_t;

   localparam mode_t MODE_STATIC = 2'b00;
   localparam mode_t MODE_BLINK  = 2'b01;
   localparam mode_t MODE_PWM    = 2'b10;
   localparam mode_t MODE_PULSE  = 2'b11;

endpackage

// File: rtl/xleds_tick.sv
// Timebase prescaler. Counts 0..TICK_DIV-1 and raises tick_o for the one
// cycle in which the count sits at TICK_DIV-1, then wraps to 0.
//   clk     in   system clock
//   reset   in   synchronous reset, active-low
//   tick_o  out  1-cycle timebase tick
module xleds_tick
   import xleds_pkg::*;
#(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == CNT_LAST);
   assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/xleds_ctrl.sv
// Multi-mode LED driver for the board LED bank. Every channel keeps its own
// mode/val/duty and a one-shot down-counter; the blink phase and PWM counter
// are global so all channels in the same mode run in lockstep.
//   clk         in   system clock
//   reset       in   synchronous reset, active-low
//   wr          in   config write strobe
//   wr_sel      in   channel mask for the write
//   wr_mode     in   mode to load (see xleds_pkg)
//   wr_val      in   STATIC level / BLINK phase invert
//   wr_duty     in   PWM duty
//   leds        out  registered LED drive
//   pulse_busy  out  registered one-shot active flags
//
// Per-channel mode (state | meaning):
//   MODE_STATIC | led follows val
//   MODE_BLINK  | led follows global phase xor val
//   MODE_PWM    | led high while pwm counter < duty
//   MODE_PULSE  | led high, counter runs down on tick; at 0 -> STATIC, val=0
module xleds_ctrl
   import xleds_pkg::*;
#(
   parameter int N_LEDS      = 8,
   parameter int PWM_W       = 4,
   parameter int TICK_DIV    = 100000,
   parameter int BLINK_TICKS = 250,
   parameter int PULSE_TICKS = 50
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [N_LEDS-1:0] wr_sel,
   input  logic [MODE_W-1:0] wr_mode,
   input  logic              wr_val,
   input  logic [PWM_W-1:0]  wr_duty,
   output logic [N_LEDS-1:0] leds,
   output logic [N_LEDS-1:0] pulse_busy
);

   localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int PCW = $clog2(PULSE_TICKS + 1);
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_TICKS - 1);
   localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_TICKS);
   localparam logic [PCW-1:0] PULSE_ONE  = PCW'(1);

   logic             tick;
   logic [BCW-1:0]   blink_cnt_q, blink_cnt_d;
   logic             phase_q, phase_d;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

   xleds_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .tick_o (tick)
   );

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Free-running; wraps 2**PWM_W-1 -> 0 naturally.
   assign pwm_cnt_d = pwm_cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         pwm_cnt_q   <= '0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         pwm_cnt_q   <= pwm_cnt_d;
      end
   end

   for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
      mode_t            mode_q, mode_d;
      logic             val_q, val_d;
      logic [PWM_W-1:0] duty_q, duty_d;
      logic [PCW-1:0]   pcnt_q, pcnt_d;
      logic             busy_q, busy_d;
      logic             led_q, led_d;

      always_comb begin
         mode_d = mode_q;
         val_d  = val_q;
         duty_d = duty_q;
         pcnt_d = pcnt_q;
         busy_d = busy_q;
         led_d  = 1'b0;

         // A write to this channel takes priority over a coincident tick,
         // so a retrigger on a tick edge starts from the full count.
         if (wr && wr_sel[i]) begin
            mode_d = wr_mode;
            val_d  = wr_val;
            duty_d = wr_duty;
            if (wr_mode == MODE_PULSE) begin
               pcnt_d = PULSE_LOAD;
               busy_d = 1'b1;
            end else begin
               pcnt_d = '0;
               busy_d = 1'b0;
            end
         end else if (busy_q && tick) begin
            if (pcnt_q == PULSE_ONE) begin
               pcnt_d = '0;
               busy_d = 1'b0;
               mode_d = MODE_STATIC;
               val_d  = 1'b0;
            end else begin
               pcnt_d = pcnt_q - 1'b1;
            end
         end

         case (mode_q)
            MODE_STATIC: led_d = val_q;
            MODE_BLINK:  led_d = phase_q ^ val_q;
            MODE_PWM:    led_d = (pwm_cnt_q < duty_q);
            MODE_PULSE:  led_d = busy_q;
            default:     led_d = 1'b0;
         endcase
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            mode_q <= MODE_STATIC;
            val_q  <= 1'b0;
            duty_q <= '0;
            pcnt_q <= '0;
            busy_q <= 1'b0;
            led_q  <= 1'b0;
         end else begin
            mode_q <= mode_d;
            val_q  <= val_d;
            duty_q <= duty_d;
            pcnt_q <= pcnt_d;
            busy_q <= busy_d;
            led_q  <= led_d;
         end
      end

      assign leds[i]       = led_q;
      assign pulse_busy[i] = busy_q;
   end

endmodule

// File: tb/tb_xleds_ctrl.sv
module tb_xleds_ctrl;
   import xleds_pkg::*;

   localparam int N_LEDS      = 4;
   localparam int PWM_W       = 2;
   localparam int TICK_DIV    = 4;
   localparam int BLINK_TICKS = 2;
   localparam int PULSE_TICKS = 3;

   logic              clk;
   logic              reset;
   logic              wr;
   logic [N_LEDS-1:0] wr_sel;
   logic [1:0]        wr_mode;
   logic              wr_val;
   logic [PWM_W-1:0]  wr_duty;
   logic [N_LEDS-1:0] leds;
   logic [N_LEDS-1:0] pulse_busy;

   int checks = 0;
   int errors = 0;
   int pre    = 0;   // timebase phase as seen by the DUT at the next edge

   xleds_ctrl #(
      .N_LEDS      (N_LEDS),
      .PWM_W       (PWM_W),
      .TICK_DIV    (TICK_DIV),
      .BLINK_TICKS (BLINK_TICKS),
      .PULSE_TICKS (PULSE_TICKS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr         (wr),
      .wr_sel     (wr_sel),
      .wr_mode    (wr_mode),
      .wr_val     (wr_val),
      .wr_duty    (wr_duty),
      .leds       (leds),
      .pulse_busy (pulse_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset) pre <= 0;
      else        pre <= (pre == TICK_DIV - 1) ? 0 : pre + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_cfg(input logic [3:0] s, input logic [1:0] m,
                         input logic v, input logic [1:0] d);
      wr = 1'b1; wr_sel = s; wr_mode = m; wr_val = v; wr_duty = d;
      step();
      wr = 1'b0; wr_sel = '0;
   endtask

   // Returns at #1 after an edge where the next edge sees prescaler value p.
   task automatic at_pre(input int p);
      int n = 0;
      while (pre != p && n < 8) begin
         step();
         n++;
      end
      checks++;
      if (pre != p) begin
         errors++;
         $display("FAIL at_pre: prescaler phase %0d required %0d", pre, p);
      end
   endtask

   // Samples ch2 for 20 cycles starting right after the pulse write edge.
   // rt_k >= 0 issues a second write to ch2 on edge W+rt_k+1.
   task automatic pulse_run(input int rt_k, input logic [1:0] rt_mode,
                            output int bc, output int lc);
      bc = 0;
      lc = 0;
      for (int k = 0; k < 20; k++) begin
         bc += int'(pulse_busy[2]);
         lc += int'(leds[2]);
         if (k == rt_k) begin
            wr = 1'b1; wr_sel = 4'b0100; wr_mode = rt_mode; wr_val = 1'b0; wr_duty = '0;
         end
         step();
         wr = 1'b0; wr_sel = '0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      wr = 1'b1; wr_sel = 4'hF; wr_mode = MODE_STATIC; wr_val = 1'b1; wr_duty = 2'd3;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (leds !== 4'b0000) begin
            errors++;
            $display("FAIL reset_leds cycle %0d: got %b required 0000", c, leds);
         end
         checks++;
         if (pulse_busy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_busy cycle %0d: got %b required 0000", c, pulse_busy);
         end
      end
      wr = 1'b0; wr_sel = '0; wr_val = 1'b0; wr_duty = '0;
      reset = 1'b1;
      repeat (3) step();
      checks++;
      if (leds !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release_leds: got %b required 0000", leds);
      end
      checks++;
      if (pulse_busy !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release_busy: got %b required 0000", pulse_busy);
      end
   endtask

   task automatic test_static();
      wr_cfg(4'b0101, MODE_STATIC, 1'b1, 2'd0);
      checks++;
      if (leds !== 4'b0000) begin
         errors++;
         $display("FAIL static_latency: got %b required 0000", leds);
      end
      step();
      checks++;
      if (leds !== 4'b0101) begin
         errors++;
         $display("FAIL static_0101: got %b required 0101", leds);
      end
      wr_cfg(4'b0001, MODE_STATIC, 1'b0, 2'd0);
      step();
      checks++;
      if (leds !== 4'b0100) begin
         errors++;
         $display("FAIL static_0100: got %b required 0100", leds);
      end
      wr_cfg(4'b0000, MODE_STATIC, 1'b1, 2'd0);
      step();
      checks++;
      if (leds !== 4'b0100) begin
         errors++;
         $display("FAIL static_sel0_noop: got %b required 0100", leds);
      end
   endtask

   task automatic test_blink();
      int  last_t   = -1;
      int  toggles  = 0;
      int  bad_int  = 0;
      int  bad_opp  = 0;
      int  bad_oth  = 0;
      logic prev;
      wr_cfg(4'b0001, MODE_BLINK, 1'b0, 2'd0);
      wr_cfg(4'b0010, MODE_BLINK, 1'b1, 2'd0);
      step();
      prev = leds[0];
      for (int t = 0; t < 48; t++) begin
         if (leds[0] === leds[1]) bad_opp++;
         if (leds[3:2] !== 2'b01) bad_oth++;
         if (leds[0] !== prev) begin
            if (last_t >= 0 && (t - last_t) != 8) bad_int++;
            last_t = t;
            toggles++;
         end
         prev = leds[0];
         step();
      end
      checks++;
      if (bad_opp != 0) begin
         errors++;
         $display("FAIL blink_opposite: %0d cycles equal, required 0", bad_opp);
      end
      checks++;
      if (toggles < 5) begin
         errors++;
         $display("FAIL blink_toggles: got %0d toggles in 48 clk, required >= 5", toggles);
      end
      checks++;
      if (bad_int != 0) begin
         errors++;
         $display("FAIL blink_period: %0d intervals not 8 clk, required 0", bad_int);
      end
      checks++;
      if (bad_oth != 0) begin
         errors++;
         $display("FAIL blink_other_channels: %0d disturbed cycles, required 0", bad_oth);
      end
   endtask

   task automatic test_pwm();
      logic [1:0] duties [3] = '{2'd2, 2'd0, 2'd3};
      int         expect_hi [3] = '{4, 0, 6};
      int         hi;
      for (int j = 0; j < 3; j++) begin
         wr_cfg(4'b1000, MODE_PWM, 1'b0, duties[j]);
         repeat (2) step();
         hi = 0;
         for (int t = 0; t < 8; t++) begin
            hi += int'(leds[3]);
            step();
         end
         checks++;
         if (hi != expect_hi[j]) begin
            errors++;
            $display("FAIL pwm_duty%0d: high %0d of 8 clk, required %0d", duties[j], hi, expect_hi[j]);
         end
      end
   endtask

   task automatic test_pulse();
      int bc, lc;
      wr_cfg(4'b0100, MODE_STATIC, 1'b0, 2'd0);
      step();
      at_pre(0);
      wr_cfg(4'b0100, MODE_PULSE, 1'b0, 2'd0);
      pulse_run(-1, MODE_PULSE, bc, lc);
      checks++;
      if (bc != 11) begin
         errors++;
         $display("FAIL pulse_busy_len: got %0d clk, required 11", bc);
      end
      checks++;
      if (lc != 11) begin
         errors++;
         $display("FAIL pulse_led_len: got %0d clk, required 11", lc);
      end

      at_pre(0);
      wr_cfg(4'b0100, MODE_PULSE, 1'b0, 2'd0);
      pulse_run(4, MODE_PULSE, bc, lc);
      checks++;
      if (bc != 15) begin
         errors++;
         $display("FAIL pulse_retrigger_busy: got %0d clk, required 15", bc);
      end
      checks++;
      if (lc != 15) begin
         errors++;
         $display("FAIL pulse_retrigger_led: got %0d clk, required 15", lc);
      end
   endtask

   task automatic test_back_to_back();
      int bc, lc;
      at_pre(TICK_DIV - 1);
      wr_cfg(4'b0100, MODE_PULSE, 1'b0, 2'd0);
      pulse_run(-1, MODE_PULSE, bc, lc);
      checks++;
      if (bc != 12) begin
         errors++;
         $display("FAIL pulse_on_tick_busy: got %0d clk, required 12", bc);
      end

      at_pre(0);
      wr_cfg(4'b0100, MODE_PULSE, 1'b0, 2'd0);
      pulse_run(4, MODE_STATIC, bc, lc);
      checks++;
      if (bc != 5) begin
         errors++;
         $display("FAIL pulse_cancel_busy: got %0d clk, required 5", bc);
      end
      checks++;
      if (lc != 5) begin
         errors++;
         $display("FAIL pulse_cancel_led: got %0d clk, required 5", lc);
      end
   endtask

   task automatic test_reset_mid();
      wr_cfg(4'b1111, MODE_PULSE, 1'b0, 2'd0);
      step();
      reset = 1'b0;
      wr = 1'b1; wr_sel = 4'hF; wr_mode = MODE_PULSE;
      step();
      checks++;
      if (pulse_busy !== 4'b0000 || leds !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid: busy %b leds %b, required 0000 0000", pulse_busy, leds);
      end
      wr = 1'b0; wr_sel = '0;
      reset = 1'b1;
      repeat (2) step();
      checks++;
      if (pulse_busy !== 4'b0000 || leds !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid_after: busy %b leds %b, required 0000 0000", pulse_busy, leds);
      end
   endtask

   initial begin
      reset = 1'b0; wr = 1'b0; wr_sel = '0; wr_mode = MODE_STATIC; wr_val = 1'b0; wr_duty = '0;
      test_reset();
      test_static();
      test_blink();
      test_pwm();
      test_pulse();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
